// File: rtl/spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// spi_rx_fifo
//
// Receive-side first-word-fall-through FIFO between the SPI master controller
// and the APB register block. Every received SPI word is pushed into the FIFO.
// The register block pops words from its head. The block also provides a fill
// level, a programmable level-threshold interrupt, a synchronous flush and a
// sticky overflow flag.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        asynchronous reset, active-high
//   wr_data_i    received word from the SPI controller
//   wr_vld_i     wr_data_i valid
//   wr_rdy_o     push ready. Tied high when DROP_ON_FULL=1, otherwise !full
//                (or a pop in the same cycle frees a slot)
//   rd_data_o    head-of-FIFO word, or 0 when the FIFO is empty
//   rd_vld_o     FIFO not empty
//   rd_en_i      pop the head word. Ignored when the FIFO is empty
//   flush_i      synchronous clear of the contents. Wins over push and pop
//   thresh_i     interrupt threshold. A value of 0 disables the interrupt
//   level_o      number of stored words, 0..DEPTH
//   irq_o        registered level interrupt: level >= thresh_i
//   ovf_o        sticky overflow flag. Set only when DROP_ON_FULL=1
//   ovf_clr_i    clears ovf_o. A set in the same cycle wins
// -----------------------------------------------------------------------------
module spi_rx_fifo #(
   parameter int  DATA_W       = 32,
   parameter int  DEPTH        = 8,
   parameter bit  DROP_ON_FULL = 1'b1,
   localparam int AW           = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic              wr_vld_i,
   output logic              wr_rdy_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_vld_o,
   input  logic              rd_en_i,
   input  logic              flush_i,
   input  logic [AW:0]       thresh_i,
   output logic [AW:0]       level_o,
   output logic              irq_o,
   output logic              ovf_o,
   input  logic              ovf_clr_i
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   // Storage and state
   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [AW:0]       wptr_q, wptr_d;
   logic [AW:0]       rptr_q, rptr_d;
   logic              ovf_q, ovf_d;
   logic              irq_q, irq_d;

   // Status and handshake
   logic              empty;
   logic              full;
   logic              pop_ok;
   logic              push_ok;
   logic              mem_we;
   logic              drop_evt;
   logic [AW:0]       next_level;

   // The pointers carry one extra wrap bit. When the lower bits are equal,
   // the wrap bit tells full apart from empty.
   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

   assign pop_ok  = rd_en_i && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push_ok = wr_vld_i && (!full || pop_ok);

   // A flush discards a concurrent push silently. It does not count as an
   // overflow.
   assign mem_we   = push_ok && !flush_i;
   assign drop_evt = DROP_ON_FULL && wr_vld_i && full && !pop_ok && !flush_i;

   // In handshake mode, rd_en_i reaches wr_rdy_o only while the FIFO is full.
   assign wr_rdy_o = DROP_ON_FULL ? 1'b1 : (!full || pop_ok);

   // Next-state logic
   always_comb begin
      // NOTE: every signal gets a default first, so no path through this
      // block leaves a value unassigned and no latch is inferred.
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      ovf_d  = ovf_q;

      if (flush_i) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (push_ok) wptr_d = wptr_q + PTR_ONE;
         if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
      end

      if (drop_evt)       ovf_d = 1'b1;
      else if (ovf_clr_i) ovf_d = 1'b0;

      // The interrupt tracks the level after this edge. It is registered,
      // so it rises together with level_o.
      next_level = wptr_d - rptr_d;
      irq_d      = (thresh_i != '0) && (next_level >= thresh_i);
   end

   // Control state
   always_ff @(posedge clk_i or posedge rst_i) begin
      // NOTE: sequential state uses non-blocking assignments only. Then every
      // flop samples its _d value from before the edge, whatever the order
      // of the statements.
      if (rst_i) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         irq_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         irq_q  <= irq_d;
      end
   end

   // NOTE: the data array has no reset. After a reset the pointers mark it
   // empty, and rd_data_o is forced to 0 while empty. Stale contents are
   // therefore never visible.
   always_ff @(posedge clk_i) begin
      if (mem_we) mem_q[wptr_q[AW-1:0]] <= wr_data_i;
   end

   // Outputs. The read path depends only on registered state.
   assign rd_vld_o  = !empty;
   assign rd_data_o = empty ? '0 : mem_q[rptr_q[AW-1:0]];
   assign level_o   = wptr_q - rptr_q;
   assign irq_o     = irq_q;
   assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_spi_rx_fifo.sv
// -----------------------------------------------------------------------------
// tb_spi_rx_fifo
//
// Directed testbench for spi_rx_fifo with default parameters
// (DATA_W=32, DEPTH=8, DROP_ON_FULL=1).
// The bench drives inputs 1 ns after each rising edge and samples outputs
// at the same point. All expected values are written out by hand below.
// -----------------------------------------------------------------------------
module tb_spi_rx_fifo;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] wr_data_i;
   logic        wr_vld_i;
   logic        wr_rdy_o;
   logic [31:0] rd_data_o;
   logic        rd_vld_o;
   logic        rd_en_i;
   logic        flush_i;
   logic [3:0]  thresh_i;
   logic [3:0]  level_o;
   logic        irq_o;
   logic        ovf_o;
   logic        ovf_clr_i;

   int n_vec = 0;
   int n_err = 0;

   spi_rx_fifo dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .wr_data_i (wr_data_i),
      .wr_vld_i  (wr_vld_i),
      .wr_rdy_o  (wr_rdy_o),
      .rd_data_o (rd_data_o),
      .rd_vld_o  (rd_vld_o),
      .rd_en_i   (rd_en_i),
      .flush_i   (flush_i),
      .thresh_i  (thresh_i),
      .level_o   (level_o),
      .irq_o     (irq_o),
      .ovf_o     (ovf_o),
      .ovf_clr_i (ovf_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock edge, then settle 1 ns past it.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push_word(input logic [31:0] d);
      wr_vld_i  = 1'b1;
      wr_data_i = d;
      tick();
      wr_vld_i  = 1'b0;
   endtask

   task automatic pop_word();
      rd_en_i = 1'b1;
      tick();
      rd_en_i = 1'b0;
   endtask

   initial begin
      rst_i     = 1'b1;
      wr_data_i = '0;
      wr_vld_i  = 1'b0;
      rd_en_i   = 1'b0;
      flush_i   = 1'b0;
      thresh_i  = '0;
      ovf_clr_i = 1'b0;

      // Reset values, checked before the first clock edge
      #3;
      check("rst_level",  32'(level_o),  32'd0);
      check("rst_rd_vld", 32'(rd_vld_o), 32'd0);
      check("rst_rd_data", rd_data_o,    32'd0);
      check("rst_irq",    32'(irq_o),    32'd0);
      check("rst_ovf",    32'(ovf_o),    32'd0);
      check("rst_wr_rdy", 32'(wr_rdy_o), 32'd1);
      tick();
      tick();
      rst_i = 1'b0;

      // 1: two pushes, then two pops
      push_word(32'hA5A5_0001);
      check("t1_vld_after_push1", 32'(rd_vld_o), 32'd1);
      check("t1_head_after_push1", rd_data_o, 32'hA5A5_0001);
      check("t1_level1", 32'(level_o), 32'd1);
      push_word(32'hA5A5_0002);
      check("t1_level2", 32'(level_o), 32'd2);
      check("t1_head_still_1", rd_data_o, 32'hA5A5_0001);
      pop_word();
      check("t1_head_2", rd_data_o, 32'hA5A5_0002);
      check("t1_level_after_pop1", 32'(level_o), 32'd1);
      pop_word();
      check("t1_vld_empty", 32'(rd_vld_o), 32'd0);
      check("t1_level0", 32'(level_o), 32'd0);
      check("t1_data_empty", rd_data_o, 32'd0);

      // 2: overflow in drop mode. The 9th word is discarded.
      for (int i = 0; i < 9; i++) begin
         push_word(32'(i));
         if (i == 7) begin
            check("t2_level_full", 32'(level_o), 32'd8);
            check("t2_ovf_before", 32'(ovf_o), 32'd0);
         end
      end
      check("t2_ovf_set", 32'(ovf_o), 32'd1);
      check("t2_level_still8", 32'(level_o), 32'd8);
      check("t2_wr_rdy_high", 32'(wr_rdy_o), 32'd1);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t2_drain%0d", i), rd_data_o, 32'(i));
         pop_word();
      end
      check("t2_empty_after_drain", 32'(rd_vld_o), 32'd0);
      check("t2_ovf_sticky", 32'(ovf_o), 32'd1);
      ovf_clr_i = 1'b1;
      tick();
      ovf_clr_i = 1'b0;
      check("t2_ovf_cleared", 32'(ovf_o), 32'd0);

      // 3: push and pop together on a full FIFO
      for (int i = 0; i < 8; i++) push_word(32'h100 + 32'(i));
      check("t3_full", 32'(level_o), 32'd8);
      wr_vld_i  = 1'b1;
      wr_data_i = 32'h55;
      rd_en_i   = 1'b1;
      #1;
      check("t3_wr_rdy", 32'(wr_rdy_o), 32'd1);
      tick();
      wr_vld_i = 1'b0;
      rd_en_i  = 1'b0;
      check("t3_level_stays8", 32'(level_o), 32'd8);
      check("t3_no_ovf", 32'(ovf_o), 32'd0);
      for (int i = 1; i < 8; i++) begin
         check($sformatf("t3_drain%0d", i), rd_data_o, 32'h100 + 32'(i));
         pop_word();
      end
      check("t3_last_is_55", rd_data_o, 32'h55);
      pop_word();
      check("t3_empty", 32'(rd_vld_o), 32'd0);

      // 4: threshold interrupt
      thresh_i = 4'd3;
      push_word(32'hC0);
      push_word(32'hC1);
      check("t4_irq_at2", 32'(irq_o), 32'd0);
      push_word(32'hC2);
      check("t4_irq_at3", 32'(irq_o), 32'd1);
      pop_word();
      check("t4_irq_after_pop", 32'(irq_o), 32'd0);
      for (int i = 0; i < 6; i++) push_word(32'hD0 + 32'(i));
      check("t4_level8", 32'(level_o), 32'd8);
      check("t4_irq_at8", 32'(irq_o), 32'd1);
      thresh_i = 4'd0;
      tick();
      check("t4_irq_disabled", 32'(irq_o), 32'd0);
      thresh_i = 4'd9;
      tick();
      check("t4_irq_thresh9", 32'(irq_o), 32'd0);
      thresh_i = 4'd8;
      tick();
      check("t4_irq_thresh8", 32'(irq_o), 32'd1);
      flush_i = 1'b1;
      tick();
      flush_i = 1'b0;
      check("t4_flush_level", 32'(level_o), 32'd0);
      check("t4_flush_irq", 32'(irq_o), 32'd0);
      thresh_i = 4'd0;

      // 5: wrap-around. 20 words pass through in blocks of 5. The first push
      //    of each block comes with a pop on an empty FIFO, which is ignored.
      for (int b = 0; b < 4; b++) begin
         for (int j = 0; j < 5; j++) begin
            wr_vld_i  = 1'b1;
            wr_data_i = 32'(b * 5 + j);
            rd_en_i   = (j == 0);
            tick();
            check($sformatf("t5_level_b%0d_%0d", b, j), 32'(level_o), 32'(j + 1));
         end
         wr_vld_i = 1'b0;
         rd_en_i  = 1'b0;
         for (int j = 0; j < 5; j++) begin
            check($sformatf("t5_data%0d", b * 5 + j), rd_data_o, 32'(b * 5 + j));
            pop_word();
         end
      end
      check("t5_level0", 32'(level_o), 32'd0);
      check("t5_no_ovf", 32'(ovf_o), 32'd0);

      // 6: flush with a concurrent push, then an asynchronous reset mid-stream
      for (int i = 0; i < 4; i++) push_word(32'h200 + 32'(i));
      check("t6_level4", 32'(level_o), 32'd4);
      flush_i   = 1'b1;
      wr_vld_i  = 1'b1;
      wr_data_i = 32'hDEAD;
      tick();
      flush_i  = 1'b0;
      wr_vld_i = 1'b0;
      check("t6_flush_level", 32'(level_o), 32'd0);
      check("t6_flush_vld", 32'(rd_vld_o), 32'd0);
      check("t6_flush_ovf", 32'(ovf_o), 32'd0);
      check("t6_flush_data", rd_data_o, 32'd0);
      thresh_i = 4'd2;
      for (int i = 0; i < 3; i++) push_word(32'h300 + 32'(i));
      check("t6_level3", 32'(level_o), 32'd3);
      check("t6_irq_before_rst", 32'(irq_o), 32'd1);
      wr_vld_i  = 1'b1;
      wr_data_i = 32'hBEEF;
      #2;
      rst_i = 1'b1;
      #1;
      check("t6_rst_level", 32'(level_o), 32'd0);
      check("t6_rst_vld", 32'(rd_vld_o), 32'd0);
      check("t6_rst_data", rd_data_o, 32'd0);
      check("t6_rst_irq", 32'(irq_o), 32'd0);
      check("t6_rst_ovf", 32'(ovf_o), 32'd0);
      check("t6_rst_wr_rdy", 32'(wr_rdy_o), 32'd1);
      tick();
      wr_vld_i = 1'b0;
      rst_i    = 1'b0;
      tick();
      check("t6_word_lost", 32'(level_o), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
- Receive-side buffer directly downstream of spi_master_controller.
- Captures every received SPI word (spi_data_rx / spi_data_rx_vld) into a first-word-fall-through FIFO; the APB register block pops words from it.
- Because the controller's rx ready input is tied high, the block never back-pressures in drop mode. On overflow it discards the new word and raises a sticky flag.
- Also provides fill level, a programmable threshold interrupt and a flush.

Parameters:
- DATA_W, 32, width of one received word
- DEPTH, 8, number of entries; power of two, >= 2
- AW, $clog2(DEPTH), pointer width (derived; not overridden)
- DROP_ON_FULL, 1, 1: wr_rdy_o held high, a push to a full FIFO is dropped and flagged; 0: wr_rdy_o = !full, true valid/ready handshake

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous reset, active-high
- wr_data_i  in  DATA_W  received word from SPI controller
- wr_vld_i  in  1  wr_data_i valid (single-cycle pulse or held)
- wr_rdy_o  out  1  push ready
- rd_data_o  out  DATA_W  head-of-FIFO word (FWFT)
- rd_vld_o  out  1  FIFO not empty
- rd_en_i  in  1  pop head; ignored when rd_vld_o=0
- flush_i  in  1  synchronous clear of contents
- thresh_i  in  AW+1  interrupt threshold (level >= thresh_i)
- level_o  out  AW+1  current number of stored words, 0..DEPTH
- irq_o  out  1  level threshold interrupt, registered
- ovf_o  out  1  sticky overflow flag
- ovf_clr_i  in  1  clears ovf_o

Behaviour:
- Reset (async, rst_i=1): wptr=rptr=0, level_o=0, rd_vld_o=0, irq_o=0, ovf_o=0, wr_rdy_o=1 (both modes). rd_data_o=0; memory contents are not reset.
- Storage: DEPTH x DATA_W register array.
- Pointers are AW+1 bits wide, the MSB being the wrap bit:
  - empty = (wptr==rptr)
  - full = (wptr[AW]!=rptr[AW]) && (wptr[AW-1:0]==rptr[AW-1:0])
- level_o = wptr - rptr, modulo 2^(AW+1). It is registered via the pointers and reflects all pushes/pops of the previous edge.
- Push accepted (push_ok) when wr_vld_i && (!full || pop_ok). A write at edge N is visible on rd_data_o/rd_vld_o after edge N (1-cycle latency).
- Pop (pop_ok) = rd_en_i && !empty. rptr advances at the edge; the next word appears on rd_data_o immediately after. rd_data_o = mem[rptr[AW-1:0]] when not empty, else 0.
- Simultaneous push+pop:
  - When empty: push only; the pop is ignored.
  - When full: both take effect, level stays DEPTH, no overflow.
  - Otherwise: both take effect, level unchanged.
- Full without pop:
  - DROP_ON_FULL=1: the word is discarded, pointers unchanged, ovf_o<=1 at that edge.
  - DROP_ON_FULL=0: wr_rdy_o=0, the upstream holds the word, ovf_o never sets.
- flush_i has priority over push/pop in the same cycle: pointers<=0, level 0, and any concurrent push is discarded without setting ovf_o.
- ovf_o: set has priority over ovf_clr_i in the same cycle; otherwise ovf_clr_i clears it.
- irq_o <= (next_level >= thresh_i) && (thresh_i != 0), registered. irq_o is a level signal, not a pulse. thresh_i=0 disables it.
- Width rules: thresh_i > DEPTH means irq_o never asserts. Pointer wrap from 2*DEPTH-1 to 0 is natural modulo arithmetic.
- Asserting rst_i mid-transfer immediately empties the FIFO; a word presented during reset is lost.
- No combinational path from rd_en_i to rd_data_o. The path rd_en_i->wr_rdy_o exists only for DROP_ON_FULL=0 and only when full.

Test Plan:
- Reset then push 0xA5A5_0001, 0xA5A5_0002 on consecutive cycles -> rd_vld_o=1 one cycle after the first push, rd_data_o=0xA5A5_0001, level_o=2; pop twice -> data 0x...0002 then rd_vld_o=0, level_o=0.
- DEPTH=8, DROP_ON_FULL=1: push 9 words 0..8 with no pop -> level_o=8, ovf_o=1 from the 9th push edge; drain -> reads 0..7, word 8 is absent; ovf_clr_i pulse -> ovf_o=0.
- Full FIFO, push 0x55 and pop in the same cycle -> level_o stays 8, ovf_o stays 0, 0x55 read last after 8 pops.
- thresh_i=3: push 3 words -> irq_o=1 on the edge after the 3rd push; one pop -> irq_o=0; thresh_i=0 with 8 words -> irq_o=0.
- Wrap-around: 20 push/pop pairs with level cycling 0..5 -> all words read in order 0..19, level_o never exceeds 5, no overflow.
- flush_i with a simultaneous push while level=4; then rst_i asserted mid-stream with level=3 -> after the flush level_o=0, rd_vld_o=0, ovf_o=0; after the reset all outputs take their reset values asynchronously, before the next clock edge.
